inst_fetch_unit: RTL and testbench

//  Instruction fetch stage feeding the single-cycle core's decode (insData/pcAddr path).

---
 rtl/inst_fetch_unit_pkg.sv | 17 +
 rtl/inst_fetch_unit_if.sv | 29 ++
 rtl/inst_fetch_unit_fetch_queue.sv | 66 ++++++
 rtl/inst_fetch_unit.sv | 104 ++++++++++
 tb/tb_inst_fetch_unit.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/inst_fetch_unit_pkg.sv
// rtl/inst_fetch_unit_pkg.sv - fetch_pkg: reset PC, FSM states and queue entry type
package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_REDIR = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_unit_if.sv
// rtl/inst_fetch_unit_if.sv - fetch_if: redirect, ROM and decode handshake bundle
interface fetch_if #(
    parameter int ROM_AW = 8
);
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic              rom_en;
    logic [ROM_AW-1:0] rom_addr;
    logic [31:0]       rom_data;
    logic              ins_valid;
    logic              ins_ready;
    logic [31:0]       ins_data;
    logic [31:0]       ins_pc;
    logic [2:0]        queue_level;
    logic [31:0]       perf_fetches;
    logic [31:0]       perf_starve;

    modport master (
        input  redirect_valid, redirect_pc, rom_data, ins_ready,
        output rom_en, rom_addr, ins_valid, ins_data, ins_pc, queue_level,
               perf_fetches, perf_starve
    );

    modport slave (
        output redirect_valid, redirect_pc, rom_data, ins_ready,
        input  rom_en, rom_addr, ins_valid, ins_data, ins_pc, queue_level,
               perf_fetches, perf_starve
    );
endinterface

// File: rtl/inst_fetch_unit_fetch_queue.sv
// rtl/inst_fetch_unit_fetch_queue.sv - fetch_queue: FIFO of {pc, ins}, clear wins over push
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             clear_i,
    input  fetch_entry_t     push_data_i,
    output fetch_entry_t     head_o,
    output logic [LVL_W-1:0] level_o,
    output logic             empty_o,
    output logic             full_o
);
    localparam int PTR_W = $clog2(DEPTH);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [LVL_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign do_push = push_i && !clear_i;
    assign do_pop  = pop_i && !empty_o && !clear_i;

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign level_o = count_q;
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == LVL_W'(DEPTH));

    // The issue rule reserves a slot for every in-flight read, so a full queue never sees a push.
    assert property (@(posedge clk) disable iff (!rst) !(push_i && full_o));

endmodule

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - instruction fetch stage; FETCH_PERF_EN adds fetch/starve counters
module inst_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
    parameter int          QUEUE_DEPTH = 4,
    parameter int          ROM_AW      = 8
) (
    input logic     clk,
    input logic     rst,
    fetch_if.master bus
);
    localparam int LVL_W = $clog2(QUEUE_DEPTH) + 1;

    fetch_state_t     state_q;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      inflight_pc_q;
    logic             inflight_q;
    logic             issue, push, pop, clear;
    logic             q_empty, q_full;
    logic [LVL_W-1:0] level;
    fetch_entry_t     head, push_entry;

    // A slot is reserved for the outstanding read so the 1-cycle ROM response always fits.
    assign issue = (state_q != S_BOOT) && !bus.redirect_valid &&
                   ((32'(level) + 32'(inflight_q)) < 32'(QUEUE_DEPTH));
    assign clear = bus.redirect_valid;
    assign push  = inflight_q && !bus.redirect_valid;
    assign pop   = !q_empty && bus.ins_ready && !bus.redirect_valid;

    assign push_entry.pc  = inflight_pc_q;
    assign push_entry.ins = bus.rom_data;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (bus.redirect_valid) fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
        else if (issue)         fetch_pc_d = fetch_pc_q + 32'd4;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_BOOT;
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            case (state_q)
                S_BOOT:  state_q <= S_RUN;
                S_RUN:   state_q <= bus.redirect_valid ? S_REDIR : S_RUN;
                S_REDIR: state_q <= bus.redirect_valid ? S_REDIR : S_RUN;
                default: state_q <= S_BOOT;
            endcase
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= issue;
            if (issue) inflight_pc_q <= fetch_pc_q;
        end
    end

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH),
        .LVL_W (LVL_W)
    ) u_queue (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .pop_i       (pop),
        .clear_i     (clear),
        .push_data_i (push_entry),
        .head_o      (head),
        .level_o     (level),
        .empty_o     (q_empty),
        .full_o      (q_full)
    );

    assign bus.rom_en      = issue;
    assign bus.rom_addr    = fetch_pc_q[ROM_AW+1:2];
    assign bus.ins_valid   = !q_empty;
    assign bus.ins_data    = head.ins;
    assign bus.ins_pc      = head.pc;
    assign bus.queue_level = 3'(level);

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetches_q, perf_starve_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetches_q <= '0;
            perf_starve_q  <= '0;
        end else begin
            if (issue && (perf_fetches_q != '1))
                perf_fetches_q <= perf_fetches_q + 32'd1;
            if ((state_q == S_RUN) && q_empty && (perf_starve_q != '1))
                perf_starve_q <= perf_starve_q + 32'd1;
        end
    end

    assign bus.perf_fetches = perf_fetches_q;
    assign bus.perf_starve  = perf_starve_q;
`else
    assign bus.perf_fetches = '0;
    assign bus.perf_starve  = '0;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb/tb_inst_fetch_unit.sv - self-checking bench for inst_fetch_unit with a stream reference model
`timescale 1ns/1ps
module tb_inst_fetch_unit;
    localparam logic [31:0] RST_PC = 32'h0040_0000;
`ifdef FETCH_PERF_EN
    localparam logic [31:0] EXP_FETCHES = 32'd4;
    localparam logic [31:0] EXP_STARVE  = 32'd2;
`else
    localparam logic [31:0] EXP_FETCHES = 32'd0;
    localparam logic [31:0] EXP_STARVE  = 32'd0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] rom_mem [256];
    int          checks = 0;
    int          failures = 0;
    int          pops = 0;
    logic [31:0] exp_pc = RST_PC;
    logic        hold = 1'b0;
    logic [31:0] hold_pc = '0;
    logic [31:0] hold_data = '0;

    fetch_if #(.ROM_AW(8)) bus ();

    inst_fetch_unit #(
        .RESET_PC    (RST_PC),
        .QUEUE_DEPTH (4),
        .ROM_AW      (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.rom_en) bus.rom_data <= rom_mem[bus.rom_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Reference model: the accepted stream is consecutive words from the last reset/redirect target.
    always begin
        @(negedge clk);
        #2;
        if (!rst) begin
            exp_pc = RST_PC;
            hold   = 1'b0;
        end else begin
            check("valid_vs_level", 32'(bus.ins_valid), 32'(bus.queue_level != 3'd0));
            check("level_bound", 32'(bus.queue_level <= 3'd4), 32'd1);
            if (hold) begin
                check("hold_valid", 32'(bus.ins_valid), 32'd1);
                check("hold_pc", bus.ins_pc, hold_pc);
                check("hold_data", bus.ins_data, hold_data);
            end
            if (bus.redirect_valid) begin
                exp_pc = bus.redirect_pc & 32'hFFFF_FFFC;
            end else if (bus.ins_valid && bus.ins_ready) begin
                check("stream_pc", bus.ins_pc, exp_pc);
                check("stream_data", bus.ins_data, rom_mem[exp_pc[9:2]]);
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
            hold      = bus.ins_valid && !bus.ins_ready && !bus.redirect_valid;
            hold_pc   = bus.ins_pc;
            hold_data = bus.ins_data;
        end
    end

    initial begin
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.ins_ready      = 1'b1;
        for (int i = 0; i < 256; i++) rom_mem[i] = 32'(i);

        // Reset values and fill latency with back-to-back delivery.
        step(2);
        check("rst_valid", 32'(bus.ins_valid), 32'd0);
        check("rst_level", 32'(bus.queue_level), 32'd0);
        check("rst_rom_en", 32'(bus.rom_en), 32'd0);
        rst = 1'b1;
        #1;
        check("boot_rom_en", 32'(bus.rom_en), 32'd0);
        step(1);
        check("run_rom_en", 32'(bus.rom_en), 32'd1);
        check("run_rom_addr", 32'(bus.rom_addr), 32'd0);
        check("fill_valid0", 32'(bus.ins_valid), 32'd0);
        step(1);
        check("fill_valid1", 32'(bus.ins_valid), 32'd0);
        for (int k = 0; k < 8; k++) begin
            step(1);
            check("b2b_valid", 32'(bus.ins_valid), 32'd1);
            check("b2b_pc", bus.ins_pc, RST_PC + 32'(4 * k));
            check("b2b_data", bus.ins_data, 32'(k));
        end

        // Backpressure from reset: queue fills, fetch stops, perf counters.
        rst = 1'b0;
        bus.ins_ready = 1'b0;
        step(1);
        rst = 1'b1;
        step(10);
        check("perf_fetches", bus.perf_fetches, EXP_FETCHES);
        check("perf_starve", bus.perf_starve, EXP_STARVE);
        check("full_level", 32'(bus.queue_level), 32'd4);
        check("full_rom_en", 32'(bus.rom_en), 32'd0);
        check("full_head_pc", bus.ins_pc, RST_PC);
        bus.ins_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("drain_valid", 32'(bus.ins_valid), 32'd1);
            check("drain_pc", bus.ins_pc, RST_PC + 32'(4 * k));
            step(1);
        end

        // Redirect while full.
        bus.ins_ready = 1'b0;
        step(8);
        check("refill_level", 32'(bus.queue_level), 32'd4);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0040_0043;
        step(1);
        bus.redirect_valid = 1'b0;
        check("redir_level", 32'(bus.queue_level), 32'd0);
        check("redir_valid0", 32'(bus.ins_valid), 32'd0);
        bus.ins_ready = 1'b1;
        step(1);
        check("redir_valid1", 32'(bus.ins_valid), 32'd0);
        step(1);
        check("redir_valid2", 32'(bus.ins_valid), 32'd1);
        check("redir_pc", bus.ins_pc, 32'h0040_0040);
        check("redir_data", bus.ins_data, 32'h10);

        // Two consecutive redirects: only the second target streams.
        step(3);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0040_0010;
        step(1);
        check("dbl_level", 32'(bus.queue_level), 32'd0);
        bus.redirect_pc = 32'h0040_0020;
        step(1);
        bus.redirect_valid = 1'b0;
        check("dbl_valid0", 32'(bus.ins_valid), 32'd0);
        step(1);
        check("dbl_valid1", 32'(bus.ins_valid), 32'd0);
        step(1);
        check("dbl_valid2", 32'(bus.ins_valid), 32'd1);
        check("dbl_pc", bus.ins_pc, 32'h0040_0020);

        // Asynchronous reset mid-stream.
        step(3);
        #2;
        rst = 1'b0;
        #1;
        check("arst_valid", 32'(bus.ins_valid), 32'd0);
        check("arst_level", 32'(bus.queue_level), 32'd0);
        step(1);
        rst = 1'b1;
        step(1);
        check("arst_rom_addr", 32'(bus.rom_addr), 32'd0);
        step(2);
        check("arst_valid2", 32'(bus.ins_valid), 32'd1);
        check("arst_pc", bus.ins_pc, RST_PC);

        // Randomized traffic against the stream model.
        rst = 1'b0;
        step(1);
        for (int i = 0; i < 256; i++) rom_mem[i] = $urandom;
        rst = 1'b1;
        step(2);
        pops = 0;
        for (int c = 0; c < 3000; c++) begin
            bus.ins_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) begin
                bus.redirect_valid = 1'b1;
                bus.redirect_pc    = ($urandom_range(0, 3) == 0) ?
                                     (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) : $urandom;
            end else begin
                bus.redirect_valid = 1'b0;
            end
            step(1);
        end
        bus.redirect_valid = 1'b0;
        step(1);
        check("rand_throughput", 32'(pops > 1000), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
